// File: rtl/alu_wide_seq_pkg.sv
// Shared definitions for the multi-word ALU sequencer: op codes, flag bit
// positions and FSM state encoding.
package alu_wide_seq_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUBC  = 4'b0010;
  localparam logic [OP_W-1:0] OP_AND   = 4'b0011;
  localparam logic [OP_W-1:0] OP_OR    = 4'b0100;
  localparam logic [OP_W-1:0] OP_NOT   = 4'b0101;
  localparam logic [OP_W-1:0] OP_XOR   = 4'b0110;
  // Shift codes exist on the ALU but are not sequenced across slices.
  localparam logic [OP_W-1:0] OP_LSL_A = 4'b0111;
  localparam logic [OP_W-1:0] OP_LSR_A = 4'b1000;
  localparam logic [OP_W-1:0] OP_ASR_A = 4'b1001;
  localparam logic [OP_W-1:0] OP_LSL_B = 4'b1010;
  localparam logic [OP_W-1:0] OP_LSR_B = 4'b1011;
  localparam logic [OP_W-1:0] OP_ASR_B = 4'b1100;

  localparam int unsigned ZERO_FLAG  = 0;
  localparam int unsigned CARRY_FLAG = 1;
  localparam int unsigned NEG_FLAG   = 2;
  localparam int unsigned OVER_FLAG  = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERR     = 3'd4
  } state_t;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return op <= OP_XOR;
  endfunction

  function automatic logic op_is_arith(input logic [OP_W-1:0] op);
    return op <= OP_SUBC;
  endfunction

endpackage

// File: rtl/alu_flag_accum.sv
// Accumulates per-slice ALU flags and forms the final {V,N,C,Z} nibble.
module alu_flag_accum
  import alu_wide_seq_pkg::*;
#(
  parameter int unsigned FlagBits = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic                i_capture,
  input  logic                i_arith,
  input  logic [FlagBits-1:0] i_oflags,
  output logic [FlagBits-1:0] o_flags_c
);

  logic                r_zero_all;
  logic [FlagBits-1:0] r_last;

  // Z is the AND over all slices; everything else comes from the last slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_all <= 1'b1;
      r_last     <= '0;
    end else if (i_clear) begin
      r_zero_all <= 1'b1;
      r_last     <= '0;
    end else if (i_capture) begin
      r_zero_all <= r_zero_all & i_oflags[ZERO_FLAG];
      r_last     <= i_oflags;
    end
  end

  always_comb begin
    o_flags_c             = '0;
    o_flags_c[ZERO_FLAG]  = r_zero_all;
    o_flags_c[CARRY_FLAG] = i_arith & r_last[CARRY_FLAG];
    o_flags_c[NEG_FLAG]   = r_last[NEG_FLAG];
    o_flags_c[OVER_FLAG]  = r_last[OVER_FLAG];
  end

endmodule

// File: rtl/alu_wide_seq.sv
// Sequences a WORDS*N-bit operation through the shared N-bit ALU one slice at
// a time, LSW first, chaining carry/borrow through the ALU input flags.
module alu_wide_seq
  import alu_wide_seq_pkg::*;
#(
  parameter int unsigned N            = 8,
  parameter int unsigned WORDS        = 4,
  parameter int unsigned SettleCycles = 1,
  parameter int unsigned FlagBits     = 4
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  input  logic                  Start,
  input  logic [OP_W-1:0]       Op,
  input  logic [N*WORDS-1:0]    OpA,
  input  logic [N*WORDS-1:0]    OpB,
  input  logic                  CarryIn,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [N*WORDS-1:0]    Result,
  output logic [FlagBits-1:0]   Flags,
  output logic [N-1:0]          AluA,
  output logic [N-1:0]          AluB,
  output logic [OP_W-1:0]       AluFuncOp,
  output logic [FlagBits-1:0]   AluIFlags,
  output logic                  AluOE_n,
  input  logic [N-1:0]          AluY,
  input  logic [FlagBits-1:0]   AluOFlags
);

  localparam int unsigned W        = N * WORDS;
  localparam int unsigned SLICE_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned SETTLE_W = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [SLICE_W-1:0]  LAST_SLICE  = SLICE_W'(WORDS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SettleCycles - 1);

  state_t               r_state;
  logic [OP_W-1:0]      r_op;
  logic [W-1:0]         r_opa;
  logic [W-1:0]         r_opb;
  logic [SLICE_W-1:0]   r_slice;
  logic [SETTLE_W-1:0]  r_settle;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic [W-1:0]         r_result;
  logic [FlagBits-1:0]  r_flags;
  logic [N-1:0]         r_alu_a;
  logic [N-1:0]         r_alu_b;
  logic [OP_W-1:0]      r_alu_func;
  logic [FlagBits-1:0]  r_alu_iflags;
  logic                 r_alu_oe_n;

  logic                 w_accept;
  logic                 w_capture;
  logic                 w_arith;
  logic [SLICE_W-1:0]   w_next_slice;
  logic [FlagBits-1:0]  w_iflags_first;
  logic [FlagBits-1:0]  w_iflags_next;
  logic [OP_W-1:0]      w_func_next;
  logic [FlagBits-1:0]  w_final_flags;

  assign w_accept     = (r_state == ST_IDLE) && Start && op_supported(Op);
  assign w_capture    = (r_state == ST_CAPTURE);
  assign w_arith      = op_is_arith(r_op);
  assign w_next_slice = r_slice + SLICE_W'(1);
  // Sub turns into borrow-chained Subc on every slice after the first.
  assign w_func_next  = (r_op == OP_SUB) ? OP_SUBC : r_op;

  // Carry/borrow into slice 0 comes from CarryIn; later slices chain the ALU carry.
  always_comb begin
    w_iflags_first             = '0;
    w_iflags_first[CARRY_FLAG] = ((Op == OP_ADD) || (Op == OP_SUBC)) ? CarryIn : 1'b0;
    w_iflags_next              = '0;
    w_iflags_next[CARRY_FLAG]  = w_arith ? AluOFlags[CARRY_FLAG] : 1'b0;
  end

  alu_flag_accum #(
    .FlagBits (FlagBits)
  ) u_flag_accum (
    .clk       (Clk),
    .rst_n     (Reset_N),
    .i_clear   (w_accept),
    .i_capture (w_capture),
    .i_arith   (w_arith),
    .i_oflags  (AluOFlags),
    .o_flags_c (w_final_flags)
  );

  // Sequencer FSM with registered status, result and ALU drive.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state      <= ST_IDLE;
      r_op         <= '0;
      r_opa        <= '0;
      r_opb        <= '0;
      r_slice      <= '0;
      r_settle     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_result     <= '0;
      r_flags      <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_func   <= '0;
      r_alu_iflags <= '0;
      r_alu_oe_n   <= 1'b1;
    end else begin
      r_busy  <= (r_state != ST_IDLE);
      r_done  <= (r_state == ST_DONE) || (r_state == ST_ERR);
      r_error <= (r_state == ST_ERR);
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_op    <= Op;
            r_opa   <= OpA;
            r_opb   <= OpB;
            r_slice <= '0;
            if (op_supported(Op)) begin
              r_state      <= ST_DRIVE;
              r_settle     <= '0;
              r_alu_a      <= OpA[N-1:0];
              r_alu_b      <= OpB[N-1:0];
              r_alu_func   <= Op;
              r_alu_iflags <= w_iflags_first;
              r_alu_oe_n   <= 1'b0;
            end else begin
              r_state <= ST_ERR;
            end
          end
        end
        ST_DRIVE: begin
          if (r_settle == SETTLE_LAST) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_settle <= r_settle + SETTLE_W'(1);
          end
        end
        ST_CAPTURE: begin
          r_result[N*int'(r_slice) +: N] <= AluY;
          if (r_slice == LAST_SLICE) begin
            r_state    <= ST_DONE;
            r_alu_oe_n <= 1'b1;
          end else begin
            r_state      <= ST_DRIVE;
            r_slice      <= w_next_slice;
            r_settle     <= '0;
            r_alu_a      <= r_opa[N*int'(w_next_slice) +: N];
            r_alu_b      <= r_opb[N*int'(w_next_slice) +: N];
            r_alu_func   <= w_func_next;
            r_alu_iflags <= w_iflags_next;
          end
        end
        ST_DONE: begin
          r_flags <= w_final_flags;
          r_state <= ST_IDLE;
        end
        ST_ERR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Error     = r_error;
  assign Result    = r_result;
  assign Flags     = r_flags;
  assign AluA      = r_alu_a;
  assign AluB      = r_alu_b;
  assign AluFuncOp = r_alu_func;
  assign AluIFlags = r_alu_iflags;
  assign AluOE_n   = r_alu_oe_n;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed bench for alu_wide_seq with an 8-bit ALU reference model on the
// slice bus; expected results are hand-computed.
module tb_alu_wide_seq;

  logic        Clk;
  logic        Reset_N;
  logic        Start;
  logic [3:0]  Op;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic        CarryIn;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [31:0] Result;
  logic [3:0]  Flags;
  logic [7:0]  AluA;
  logic [7:0]  AluB;
  logic [3:0]  AluFuncOp;
  logic [3:0]  AluIFlags;
  logic        AluOE_n;
  logic [7:0]  AluY;
  logic [3:0]  AluOFlags;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_wide_seq dut (
    .Clk       (Clk),
    .Reset_N   (Reset_N),
    .Start     (Start),
    .Op        (Op),
    .OpA       (OpA),
    .OpB       (OpB),
    .CarryIn   (CarryIn),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error),
    .Result    (Result),
    .Flags     (Flags),
    .AluA      (AluA),
    .AluB      (AluB),
    .AluFuncOp (AluFuncOp),
    .AluIFlags (AluIFlags),
    .AluOE_n   (AluOE_n),
    .AluY      (AluY),
    .AluOFlags (AluOFlags)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // 8-bit ALU reference: returns {V,N,C,Z, Y}; C is carry for Add, borrow for Sub/Subc.
  function automatic logic [11:0] alu_model(input logic [3:0] f, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
    logic [8:0] t;
    logic [7:0] y;
    logic       c;
    logic       v;
    t = '0;
    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (f)
      4'h0: begin
        t = {1'b0, a} + {1'b0, b} + 9'(cin);
        y = t[7:0]; c = t[8]; v = (a[7] == b[7]) && (y[7] != a[7]);
      end
      4'h1: begin
        t = {1'b0, a} - {1'b0, b};
        y = t[7:0]; c = t[8]; v = (a[7] != b[7]) && (y[7] != a[7]);
      end
      4'h2: begin
        t = {1'b0, a} - {1'b0, b} - 9'(cin);
        y = t[7:0]; c = t[8]; v = (a[7] != b[7]) && (y[7] != a[7]);
      end
      4'h3: y = a & b;
      4'h4: y = a | b;
      4'h5: y = ~a;
      4'h6: y = a ^ b;
      default: y = '0;
    endcase
    return {v, y[7], c, (y == 8'h00), y};
  endfunction

  assign {AluOFlags, AluY} = AluOE_n ? 12'h000 : alu_model(AluFuncOp, AluA, AluB, AluIFlags[1]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for Done; optionally poke Start while busy.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input int poke_edge,
                        output int done_edge, output logic err, output logic oe_low,
                        output logic busy_at_done, output logic stray_iflags);
    @(negedge Clk);
    Start = 1'b1; Op = op; OpA = a; OpB = b; CarryIn = cin;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    done_edge = -1; err = 1'b0; busy_at_done = 1'b0; stray_iflags = 1'b0;
    oe_low = !AluOE_n;
    for (int e = 1; e <= 30; e++) begin
      @(posedge Clk);
      @(negedge Clk);
      Start = (e == poke_edge);
      if (e == poke_edge) begin
        Op = 4'h1; OpA = 32'h1234_5678; OpB = 32'h8765_4321; CarryIn = 1'b1;
      end
      if (!AluOE_n) oe_low = 1'b1;
      if (AluIFlags[3] || AluIFlags[2] || AluIFlags[0]) stray_iflags = 1'b1;
      if (Done) begin
        done_edge = e; err = Error; busy_at_done = Busy;
        Start = 1'b0;
        break;
      end
    end
    Start = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      if (Done) n++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " busy"},   32'(Busy),      32'h0);
    check({tag, " done"},   32'(Done),      32'h0);
    check({tag, " error"},  32'(Error),     32'h0);
    check({tag, " result"}, Result,         32'h0);
    check({tag, " flags"},  32'(Flags),     32'h0);
    check({tag, " alu_a"},  32'(AluA),      32'h0);
    check({tag, " alu_b"},  32'(AluB),      32'h0);
    check({tag, " func"},   32'(AluFuncOp), 32'h0);
    check({tag, " iflags"}, 32'(AluIFlags), 32'h0);
    check({tag, " oe_n"},   32'(AluOE_n),   32'h1);
  endtask

  task automatic do_and_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic cin,
                              input logic [31:0] exp_res, input logic [3:0] exp_flags);
    int   de;
    logic er, ol, bd, si;
    run_op(op, a, b, cin, 0, de, er, ol, bd, si);
    check({tag, " done_edge"}, 32'(de),    32'd9);
    check({tag, " error"},     32'(er),    32'h0);
    check({tag, " busy"},      32'(bd),    32'h1);
    check({tag, " iflags"},    32'(si),    32'h0);
    check({tag, " result"},    Result,     exp_res);
    check({tag, " flags"},     32'(Flags), 32'(exp_flags));
  endtask

  initial begin
    int   de;
    int   nd;
    logic er, ol, bd, si;

    Reset_N = 1'b0; Start = 1'b0; Op = '0; OpA = '0; OpB = '0; CarryIn = 1'b0;
    repeat (3) @(negedge Clk);
    check_reset_vals("reset");
    Reset_N = 1'b1;

    do_and_check("add_carry_chain", 4'h0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 4'h0);
    do_and_check("add_wrap",        4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'h3);
    do_and_check("add_cin",         4'h0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'h3);
    do_and_check("add_ovf",         4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'hC);
    do_and_check("sub_borrow_cin",  4'h1, 32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FF, 4'h0);
    do_and_check("sub_neg",         4'h1, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 4'h6);
    do_and_check("subc_bin",        4'h2, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 4'h6);
    do_and_check("and",             4'h3, 32'hF0F0_FFFF, 32'h0FF0_F00F, 1'b1, 32'h00F0_F00F, 4'h0);
    do_and_check("or",              4'h4, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h8000_0001, 4'h4);
    do_and_check("xor_zero",        4'h6, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 32'h0000_0000, 4'h1);
    do_and_check("not",             4'h5, 32'h0F0F_0F0F, 32'h1234_5678, 1'b0, 32'hF0F0_F0F0, 4'h4);

    // Unsupported op: immediate Done+Error, bus stays released, outputs untouched.
    run_op(4'h8, 32'h1111_1111, 32'h2222_2222, 1'b0, 0, de, er, ol, bd, si);
    check("err done_edge", 32'(de),    32'd1);
    check("err error",     32'(er),    32'h1);
    check("err oe_low",    32'(ol),    32'h0);
    check("err result",    Result,     32'hF0F0_F0F0);
    check("err flags",     32'(Flags), 32'h4);

    // Reset during slice 2 aborts with no Done afterwards.
    @(negedge Clk);
    Start = 1'b1; Op = 4'h0; OpA = 32'h00FF_FFFF; OpB = 32'h0000_0001; CarryIn = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #2;
    check("pre_abort result", Result, 32'hF0F0_0000);
    Reset_N = 1'b0;
    #1;
    check_reset_vals("abort");
    @(negedge Clk);
    Reset_N = 1'b1;
    count_done(15, nd);
    check("abort no_done", 32'(nd), 32'h0);

    // Start while busy is ignored and does not disturb the running operation.
    run_op(4'h0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 3, de, er, ol, bd, si);
    check("busy_start done_edge", 32'(de),    32'd9);
    check("busy_start result",    Result,     32'h0100_0000);
    check("busy_start flags",     32'(Flags), 32'h0);
    count_done(15, nd);
    check("busy_start no_extra",  32'(nd),    32'h0);
    check("idle oe_n",            32'(AluOE_n), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
